// File: rtl/cpu_pkg.sv
// Shared definitions for the 8-bit datapath.
//   DATA_W / REG_AW : default data width and register index width
//   op_t            : execute-stage operation codes
//   exec_state_t    : execute/write-back stage FSM states
package cpu_pkg;

  localparam int DATA_W = 8;
  localparam int REG_AW = 3;

  typedef enum logic [2:0] {
    OP_ADD = 3'b000,
    OP_SUB = 3'b001,
    OP_AND = 3'b010,
    OP_OR  = 3'b011,
    OP_XOR = 3'b100,
    OP_SLT = 3'b101,
    OP_SHL = 3'b110,
    OP_MUL = 3'b111
  } op_t;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_MUL  = 2'd1,
    ST_WB   = 2'd2
  } exec_state_t;

endpackage

// File: rtl/exec_wb_stage_mul_iter.sv
// Iterative shift-add multiplier (module mul_iter).
//   clock, reset_n : clock and synchronous active-low reset
//   start          : load a/b and begin; a start while busy restarts
//   a, b           : multiplicand / multiplier
//   busy           : iterations still outstanding
//   product        : full 2*WIDTH product, final once busy drops
// Bit 0 of b is consumed on the start edge itself, so the last partial
// product lands WIDTH-1 edges later and the product is stable one full
// cycle before the owner needs to register it.
module mul_iter
  import cpu_pkg::*;
#(
  parameter int WIDTH = DATA_W
) (
  input  logic               clock,
  input  logic               reset_n,
  input  logic               start,
  input  logic [WIDTH-1:0]   a,
  input  logic [WIDTH-1:0]   b,
  output logic               busy,
  output logic [2*WIDTH-1:0] product
);

  localparam int CW = $clog2(WIDTH + 1);

  logic [CW-1:0]      r_count;
  logic [2*WIDTH-1:0] r_acc;
  logic [2*WIDTH-1:0] r_mcand;
  logic [WIDTH-1:0]   r_mplier;

  always_ff @(posedge clock) begin
    if (!reset_n) begin
      r_count  <= '0;
      r_acc    <= '0;
      r_mcand  <= '0;
      r_mplier <= '0;
    end else if (start) begin
      r_acc    <= b[0] ? {{WIDTH{1'b0}}, a} : '0;
      r_mcand  <= {{(WIDTH-1){1'b0}}, a, 1'b0};
      r_mplier <= b >> 1;
      r_count  <= CW'(WIDTH - 1);
    end else if (busy) begin
      r_acc    <= r_acc + (r_mplier[0] ? r_mcand : '0);
      r_mcand  <= r_mcand << 1;
      r_mplier <= r_mplier >> 1;
      r_count  <= r_count - CW'(1);
    end
  end

  assign busy    = (r_count != '0);
  assign product = r_acc;

endmodule

// File: rtl/exec_wb_stage.sv
// Execute/write-back stage: ALU plus iterative multiplier, driving the
// register file write port for one cycle per accepted operation.
//   clock, reset_n          : clock, synchronous active-low reset
//   in_valid / in_ready     : operation handshake from decode
//   op, dest, operand_a/b   : operation, destination index, operands
//   reg_write/wr_addr/wr_data : register file write port (r0 suppressed)
//   done                    : one-cycle pulse per completed operation
//   flag_zero / flag_carry  : flags of the last completed operation
//   o_dbg_state             : current FSM state
// Handshake: an operation transfers on a rising edge where in_valid and
// in_ready are both high; in_ready depends on state only, and decode must
// hold its fields stable while in_valid is high and in_ready is low.
module exec_wb_stage
  import cpu_pkg::*;
#(
  parameter int WIDTH = DATA_W,
  parameter int AW    = REG_AW
) (
  input  logic             clock,
  input  logic             reset_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [2:0]       op,
  input  logic [AW-1:0]    dest,
  input  logic [WIDTH-1:0] operand_a,
  input  logic [WIDTH-1:0] operand_b,
  output logic             reg_write,
  output logic [AW-1:0]    wr_addr,
  output logic [WIDTH-1:0] wr_data,
  output logic             done,
  output logic             flag_zero,
  output logic             flag_carry,
  output exec_state_t      o_dbg_state
);

  exec_state_t r_state, w_next_state;

  logic               w_accept;
  op_t                w_op;
  logic               w_mul_start;
  logic               w_mul_busy;
  logic [2*WIDTH-1:0] w_mul_product;
  logic [WIDTH:0]     w_sum;
  logic [WIDTH-1:0]   w_alu_res;
  logic               w_alu_carry;
  logic [WIDTH-1:0]   w_wb_data;
  logic [AW-1:0]      w_wb_addr;
  logic               w_wb_carry;
  logic [AW-1:0]      r_dest;
  logic               r_reg_write;
  logic [AW-1:0]      r_wr_addr;
  logic [WIDTH-1:0]   r_wr_data;
  logic               r_done;
  logic               r_flag_zero;
  logic               r_flag_carry;

  assign in_ready    = (r_state != ST_MUL);
  assign w_accept    = in_valid && in_ready;
  assign w_op        = op_t'(op);
  assign w_mul_start = w_accept && (w_op == OP_MUL);

  mul_iter #(.WIDTH(WIDTH)) u_mul (
    .clock   (clock),
    .reset_n (reset_n),
    .start   (w_mul_start),
    .a       (operand_a),
    .b       (operand_b),
    .busy    (w_mul_busy),
    .product (w_mul_product)
  );

  // Single-cycle ALU for every op except MUL.
  assign w_sum = {1'b0, operand_a} + {1'b0, operand_b};

  always_comb begin
    w_alu_res   = '0;
    w_alu_carry = 1'b0;
    case (w_op)
      OP_ADD: begin
        w_alu_res   = w_sum[WIDTH-1:0];
        w_alu_carry = w_sum[WIDTH];
      end
      OP_SUB: begin
        w_alu_res   = operand_a - operand_b;
        w_alu_carry = (operand_a < operand_b);
      end
      OP_AND: w_alu_res = operand_a & operand_b;
      OP_OR:  w_alu_res = operand_a | operand_b;
      OP_XOR: w_alu_res = operand_a ^ operand_b;
      OP_SLT: w_alu_res = {{(WIDTH-1){1'b0}}, (operand_a < operand_b)};
      OP_SHL: w_alu_res = operand_a << operand_b[2:0];
      default: begin
        w_alu_res   = '0;
        w_alu_carry = 1'b0;
      end
    endcase
  end

  always_ff @(posedge clock) begin
    if (!reset_n) r_state <= ST_IDLE;
    else          r_state <= w_next_state;
  end

  always_comb begin
    w_next_state = ST_IDLE;
    case (r_state)
      ST_IDLE, ST_WB: begin
        if (w_accept) w_next_state = (w_op == OP_MUL) ? ST_MUL : ST_WB;
        else          w_next_state = ST_IDLE;
      end
      ST_MUL:  w_next_state = w_mul_busy ? ST_MUL : ST_WB;
      default: w_next_state = ST_IDLE;
    endcase
  end

  // Write-back source: the multiplier when leaving MUL, else the ALU.
  assign w_wb_data  = (r_state == ST_MUL) ? w_mul_product[WIDTH-1:0] : w_alu_res;
  assign w_wb_addr  = (r_state == ST_MUL) ? r_dest : dest;
  assign w_wb_carry = (r_state == ST_MUL) ? (|w_mul_product[2*WIDTH-1:WIDTH])
                                          : w_alu_carry;

  always_ff @(posedge clock) begin
    if (!reset_n) begin
      r_dest       <= '0;
      r_reg_write  <= 1'b0;
      r_wr_addr    <= '0;
      r_wr_data    <= '0;
      r_done       <= 1'b0;
      r_flag_zero  <= 1'b0;
      r_flag_carry <= 1'b0;
    end else begin
      r_reg_write <= 1'b0;
      r_done      <= 1'b0;
      if (w_accept) r_dest <= dest;
      if (w_next_state == ST_WB) begin
        r_reg_write  <= (w_wb_addr != '0);
        r_wr_addr    <= w_wb_addr;
        r_wr_data    <= w_wb_data;
        r_done       <= 1'b1;
        r_flag_zero  <= (w_wb_data == '0);
        r_flag_carry <= w_wb_carry;
      end
    end
  end

  assign reg_write   = r_reg_write;
  assign wr_addr     = r_wr_addr;
  assign wr_data     = r_wr_data;
  assign done        = r_done;
  assign flag_zero   = r_flag_zero;
  assign flag_carry  = r_flag_carry;
  assign o_dbg_state = r_state;

endmodule

// File: doc/exec_wb_stage.md
# exec_wb_stage

Execute/write-back stage of the 8-bit datapath, directly downstream of the register file. It takes the two read operands (`Data1`, `Data2`), an operation code and a destination index. It computes the result with an ALU; multiplication uses an iterative shift-add unit. It then drives the register file's write port (`RegWrite`, `EscReg`, `WriteData`) for exactly one cycle per accepted operation, and uses a valid/ready handshake so the decode stage stalls during multi-cycle operations.

## Interface
- `WIDTH`, 8, data width; matches register file word
- `AW`, 3, register index width; 8 registers
- `clock`  in  1  single clock; all state updates on rising edge
- `reset_n`  in  1  reset, synchronous, active-low
- `in_valid`  in  1  operation presented by decode
- `in_ready`  out  1  stage can accept; transfer when `in_valid && in_ready` at a rising edge
- `op`  in  3  operation code, see Operation
- `dest`  in  AW  destination register index
- `operand_a`  in  WIDTH  from register file `Data1`
- `operand_b`  in  WIDTH  from register file `Data2`
- `reg_write`  out  1  to `RegWrite`
- `wr_addr`  out  AW  to `EscReg`
- `wr_data`  out  WIDTH  to `WriteData`
- `done`  out  1  one-cycle pulse per completed operation, including writes to r0
- `flag_zero`  out  1  last result == 0
- `flag_carry`  out  1  last carry/borrow/overflow, see Operation

## Operation
- Op codes: 000 ADD, 001 SUB (a−b), 010 AND, 011 OR, 100 XOR, 101 SLT (unsigned, result 1/0), 110 SHL (a << b[2:0]), 111 MUL (low WIDTH bits of a×b).
- All arithmetic is unsigned, modulo 2^WIDTH.
- `flag_carry` rules:
  - ADD: carry-out.
  - SUB: borrow (a<b).
  - MUL: any nonzero bit in product[2W−1:W].
  - All other ops: 0.
- FSM states:
  - IDLE: `in_ready`=1. On accept, a non-MUL op computes its result combinationally, registers it and goes to WB. MUL latches a, b and dest and goes to MUL.
  - MUL: `in_ready`=0. One shift-add step per cycle for WIDTH cycles, then WB.
  - WB: `done`=1 and `reg_write`=(dest_q != 0). `wr_addr`/`wr_data` hold the result. `in_ready`=1. An accept in WB follows the same rules as IDLE, giving back-to-back operation. With no accept, go to IDLE.
- Writes to r0 are suppressed (`reg_write`=0) but still produce `done` and update flags.
- Flags are registered on entry to WB and hold until the next WB.
- Reset values: state IDLE; `reg_write`, `done`, `flag_zero` and `flag_carry` = 0; `wr_addr` and `wr_data` = 0; `in_ready`=1 after reset deasserts.
- Reset mid-MUL aborts the operation: no write, no `done`. Operands are discarded.
- Inputs are sampled only on the accept edge. Changes at any other time are ignored.

## Timing
- Accept at edge 0.
- Non-MUL: `reg_write`/`done` high in cycle 1 (after edge 0, until edge 1). Latency 1. Sustained throughput 1 op/cycle.
- MUL: iterations occupy cycles 1..WIDTH; WB in cycle WIDTH+1 (cycle 9 at WIDTH=8). `in_ready` is low in cycles 1..WIDTH.
- The register file writes on the edge that ends the WB cycle. The next op, if it reads `dest`, observes the new value from that edge onward. Decode owns hazard handling; this stage does not forward.
- All outputs are registered. `in_ready` is decoded from state only; it does not depend on `in_valid` combinationally.

## Structure
- Shared package `cpu_pkg` contains:
  - `op_t` enum for the 8 op codes.
  - `exec_state_t` enum: IDLE, MUL, WB.
  - Constants `DATA_W`=8 and `REG_AW`=3.
- Sub-module `mul_iter` holds the shift-add multiplier:
  - Inputs: start, a, b.
  - Outputs: busy, product[2W−1:0].
  - Internal: counter of $clog2(WIDTH+1) bits.
  - A start while busy restarts it. Synchronous active-low reset.
- The ALU stays inline as a combinational case on `op_t`.

## Test plan
- Reset, then ADD a=0xF0 b=0x20 dest=3 → cycle 1: `reg_write`=1, `wr_addr`=3, `wr_data`=0x10, `flag_carry`=1, `flag_zero`=0.
- SUB a=0x05 b=0x05 dest=0 → `done`=1, `reg_write`=0, `flag_zero`=1, `flag_carry`=0.
- MUL a=0x13 b=0x0F dest=2 → `in_ready` low cycles 1..8; cycle 9 `wr_data`=0x1D, `flag_carry`=1 (product 0x011D).
- Back-to-back: `in_valid` held with ADD(1,1,d1), AND(0xFF,0x0F,d2), SHL(0x81,3,d3) → writes in cycles 1,2,3 of 0x02, 0x0F, 0x08.
- Reset asserted in cycle 4 of MUL a=0xFF b=0xFF → no `reg_write`/`done` afterwards; a following ADD(2,3,d4) writes 0x05 normally.
- SLT a=0x7F b=0x80 → `wr_data`=0x01. SLT a=0x80 b=0x7F → `wr_data`=0x00, `flag_zero`=1.
